// File: rtl/i2c_bus_frontend_pkg.sv
// rtl/i2c_bus_frontend_pkg.sv - shared I2C constants and bus-state type
package i2c_bus_frontend_pkg;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - per-line synchroniser, glitch filter and edge pulses
module i2c_line_filter
    import i2c_bus_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk_25,
    input  logic reset_n,
    input  logic pin,
    output logic filt,
    output logic front,
    output logic back
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   prev;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE}};
            filt   <= LINE_IDLE;
            prev   <= LINE_IDLE;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev   <= filt;
            // A new level is only adopted after FILT_LEN consecutive differing samples
            if (sync == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                filt <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign front = filt & ~prev;
    assign back  = ~filt & prev;

endmodule

// File: rtl/i2c_bus_frontend.sv
// rtl/i2c_bus_frontend.sv - I2C pad conditioning: filtering, START/STOP, busy, SCL timeout
module i2c_bus_frontend
    import i2c_bus_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic clk_25,
    input  logic reset_n,
    input  logic sda_in,
    input  logic scl_in,
    input  logic slv_data_out,
    output logic mst_sda,
    output logic front_sda,
    output logic back_sda,
    output logic mst_scl,
    output logic front_scl,
    output logic back_scl,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_timeout,
    output logic sda_oe
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    bus_state_t    state_q;
    bus_state_t    state_d;
    logic [TW-1:0] tcnt;
    logic          scl_edge;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filter (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .pin     (sda_in),
        .filt    (mst_sda),
        .front   (front_sda),
        .back    (back_sda)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filter (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .pin     (scl_in),
        .filt    (mst_scl),
        .front   (front_scl),
        .back    (back_scl)
    );

    // A simultaneous SCL fall leaves mst_scl low, which masks the condition
    assign start_det = back_sda & mst_scl;
    assign stop_det  = front_sda & mst_scl;
    assign scl_edge  = front_scl | back_scl;
    assign bus_busy  = (state_q == BUS_BUSY);

    assign bus_timeout = bus_busy & ~mst_scl & ~scl_edge & (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (start_det)              state_d = BUS_BUSY;
            BUS_BUSY: if (bus_timeout | stop_det) state_d = BUS_IDLE;
            default:                              state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (!bus_busy || scl_edge || bus_timeout) begin
            tcnt <= '0;
        end else if (!mst_scl) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            sda_oe <= 1'b0;
        end else begin
            sda_oe <= ~slv_data_out;
        end
    end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb/tb_i2c_bus_frontend.sv - self-checking bench for i2c_bus_frontend
module tb_i2c_bus_frontend;

    logic clk_25 = 1'b0;
    logic reset_n;
    logic sda_in, scl_in, slv_data_out;
    logic mst_sda, front_sda, back_sda, mst_scl, front_scl, back_scl;
    logic start_det, stop_det, bus_busy, bus_timeout, sda_oe;

    int checks   = 0;
    int failures = 0;

    int n_back_sda = 0, n_front_sda = 0, n_front_scl = 0;
    int n_start = 0, n_stop = 0, n_timeout = 0;

    typedef struct {
        int len;
        int exp_edges;
    } glitch_vec_t;

    glitch_vec_t gv[4];
    logic        oe_vals[6];
    logic        exp_q[$];

    i2c_bus_frontend dut (
        .clk_25       (clk_25),
        .reset_n      (reset_n),
        .sda_in       (sda_in),
        .scl_in       (scl_in),
        .slv_data_out (slv_data_out),
        .mst_sda      (mst_sda),
        .front_sda    (front_sda),
        .back_sda     (back_sda),
        .mst_scl      (mst_scl),
        .front_scl    (front_scl),
        .back_scl     (back_scl),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy),
        .bus_timeout  (bus_timeout),
        .sda_oe       (sda_oe)
    );

    always #20 clk_25 = ~clk_25;

    always @(negedge clk_25) begin
        n_back_sda  <= n_back_sda  + int'(back_sda);
        n_front_sda <= n_front_sda + int'(front_sda);
        n_front_scl <= n_front_scl + int'(front_scl);
        n_start     <= n_start     + int'(start_det);
        n_stop      <= n_stop      + int'(stop_det);
        n_timeout   <= n_timeout   + int'(bus_timeout);
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sda_in = b;
        step(65);
        scl_in = 1'b1;
        step(125);
        scl_in = 1'b0;
        step(60);
    endtask

    initial begin
        int b0, f0, s0, p0, t0, c0;
        logic [7:0] frame_byte;
        logic exp_oe;

        gv[0] = '{len: 1, exp_edges: 0};
        gv[1] = '{len: 3, exp_edges: 0};
        gv[2] = '{len: 4, exp_edges: 1};
        gv[3] = '{len: 7, exp_edges: 1};
        oe_vals[0] = 1'b1; oe_vals[1] = 1'b0; oe_vals[2] = 1'b1;
        oe_vals[3] = 1'b0; oe_vals[4] = 1'b0; oe_vals[5] = 1'b1;

        reset_n = 1'b0; sda_in = 1'b1; scl_in = 1'b1; slv_data_out = 1'b1;
        step(3);
        check("rst_mst_sda", mst_sda, 1);
        check("rst_mst_scl", mst_scl, 1);
        check("rst_busy", bus_busy, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_pulses", {back_sda, front_sda, back_scl, front_scl, start_det, stop_det, bus_timeout}, 0);
        reset_n = 1'b1;
        step(10);

        // START latency: pin change sampled on edge 1 shows after edge 6
        sda_in = 1'b0;
        step(5);
        check("t1_back_early", back_sda, 0);
        check("t1_mst_sda_early", mst_sda, 1);
        step(1);
        check("t1_back_sda", back_sda, 1);
        check("t1_start_det", start_det, 1);
        check("t1_busy_pre", bus_busy, 0);
        step(1);
        check("t1_busy", bus_busy, 1);
        check("t1_back_one_cycle", back_sda, 0);
        sda_in = 1'b1;
        step(6);
        check("t1_stop_det", stop_det, 1);
        step(1);
        check("t1_busy_clear", bus_busy, 0);
        step(10);

        // Glitch rejection table
        for (int i = 0; i < 4; i++) begin
            b0 = n_back_sda; f0 = n_front_sda; s0 = n_start; p0 = n_stop;
            sda_in = 1'b0;
            step(gv[i].len);
            sda_in = 1'b1;
            step(20);
            check($sformatf("t2_back_len%0d", gv[i].len), n_back_sda - b0, gv[i].exp_edges);
            check($sformatf("t2_front_len%0d", gv[i].len), n_front_sda - f0, gv[i].exp_edges);
            check($sformatf("t2_start_len%0d", gv[i].len), n_start - s0, gv[i].exp_edges);
            check($sformatf("t2_stop_len%0d", gv[i].len), n_stop - p0, gv[i].exp_edges);
            check($sformatf("t2_mst_sda_len%0d", gv[i].len), mst_sda, 1);
            check($sformatf("t2_busy_len%0d", gv[i].len), bus_busy, 0);
        end

        // sda_oe scoreboard: expected pushed at drive, popped after the next edge
        exp_oe = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slv_data_out = oe_vals[i];
            exp_q.push_back(~oe_vals[i]);
            check($sformatf("t5_oe_hold%0d", i), sda_oe, exp_oe);
            step(1);
            exp_oe = exp_q.pop_front();
            check($sformatf("t5_oe%0d", i), sda_oe, exp_oe);
        end
        slv_data_out = 1'b1;
        step(2);

        // 0x70 write frame at 100 kHz, then STOP
        f0 = n_front_scl; s0 = n_start; p0 = n_stop;
        frame_byte = 8'h70;
        sda_in = 1'b0;
        step(125);
        scl_in = 1'b0;
        step(60);
        for (int i = 7; i >= 0; i--) send_bit(frame_byte[i]);
        send_bit(1'b0);
        check("t3_front_scl_9", n_front_scl - f0, 9);
        check("t3_busy_mid", bus_busy, 1);
        sda_in = 1'b0;
        step(65);
        scl_in = 1'b1;
        step(125);
        sda_in = 1'b1;
        step(125);
        check("t3_start_once", n_start - s0, 1);
        check("t3_stop_once", n_stop - p0, 1);
        check("t3_busy_end", bus_busy, 0);

        // SCL stuck low timeout
        t0 = n_timeout;
        sda_in = 1'b0;
        step(20);
        scl_in = 1'b0;
        step(6);
        check("t4_back_scl", back_scl, 1);
        step(24999);
        check("t4_timeout_early", bus_timeout, 0);
        check("t4_busy_before", bus_busy, 1);
        step(1);
        check("t4_timeout_pulse", bus_timeout, 1);
        step(1);
        check("t4_timeout_one_cycle", bus_timeout, 0);
        check("t4_busy_after", bus_busy, 0);
        check("t4_timeout_count", n_timeout - t0, 1);

        // SCL toggle just before expiry restarts the count
        sda_in = 1'b1;
        step(20);
        scl_in = 1'b1;
        step(20);
        sda_in = 1'b0;
        step(20);
        check("t4r_busy", bus_busy, 1);
        t0 = n_timeout;
        scl_in = 1'b0;
        step(6);
        check("t4r_back_scl", back_scl, 1);
        step(24984);
        scl_in = 1'b1;
        step(10);
        scl_in = 1'b0;
        step(40);
        check("t4r_no_timeout", n_timeout - t0, 0);
        check("t4r_busy_held", bus_busy, 1);
        scl_in = 1'b1;
        step(20);
        sda_in = 1'b1;
        step(20);
        check("t4r_busy_stop", bus_busy, 0);

        // Reset mid-transfer with SDA low, SCL high
        slv_data_out = 1'b0;
        step(2);
        check("t6_oe_before", sda_oe, 1);
        sda_in = 1'b0;
        step(20);
        check("t6_busy_before", bus_busy, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_mst_sda", mst_sda, 1);
        check("t6_rst_busy", bus_busy, 0);
        check("t6_rst_sda_oe", sda_oe, 0);
        check("t6_rst_back", back_sda, 0);
        step(2);
        reset_n = 1'b1;
        c0 = n_start;
        step(5);
        check("t6_back_early", back_sda, 0);
        step(1);
        check("t6_back_sda", back_sda, 1);
        check("t6_start_det", start_det, 1);
        step(1);
        check("t6_busy_again", bus_busy, 1);
        check("t6_start_count", n_start - c0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
